fb_frame_streamer: RTL and testbench



---
 rtl/fb_frame_streamer.sv | 103 ++++++++++
 tb/tb_fb_frame_streamer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_frame_streamer.sv
// Frame-rate tick generator and framebuffer streamer: sends SYNC_BYTE followed by the
// framebuffer over a byte handshake, sharing the framebuffer read port with a higher-priority CPU.
module fb_frame_streamer #(
  parameter int         CLKS_PER_FRAME = 833333,
  parameter int         FB_BYTES       = 256,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cpu_rd_req,
  input  logic [7:0] cpu_addr,
  output logic [7:0] fb_addr,
  output logic       fb_rd_en,
  input  logic [7:0] fb_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_tick,
  output logic       busy,
  output logic [7:0] drop_cnt
);
  localparam int            CW        = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_FRAME - 1);
  localparam logic [8:0]    IDX_LAST  = 9'(FB_BYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, REQ, WAIT, SEND} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tick_cnt;
  logic [8:0]    idx, idx_nxt;
  logic [7:0]    tx_data_nxt;
  logic          tx_valid_nxt;
  logic          xfer;

  assign frame_tick = en && (tick_cnt == TICK_LAST);
  assign xfer       = tx_valid && tx_ready;
  assign busy       = (state != IDLE);

  // CPU always wins the read port; the streamer only drives it while parked in REQ.
  assign fb_rd_en = cpu_rd_req | (state == REQ);
  assign fb_addr  = cpu_rd_req ? cpu_addr : ((state == REQ) ? idx[7:0] : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tick_cnt <= '0;
    else if (!en)        tick_cnt <= '0;
    else if (frame_tick) tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= 8'h00;
    else if (frame_tick && busy && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    case (state)
      IDLE: if (frame_tick) begin
        idx_nxt      = '0;
        tx_data_nxt  = SYNC_BYTE;
        tx_valid_nxt = 1'b1;
        state_nxt    = HDR;
      end
      HDR: if (xfer) begin
        tx_valid_nxt = 1'b0;
        state_nxt    = REQ;
      end
      REQ: if (!cpu_rd_req) state_nxt = WAIT;
      // fb_rdata here belongs to the REQ-cycle address even if the CPU reads now.
      WAIT: begin
        tx_data_nxt  = fb_rdata;
        tx_valid_nxt = 1'b1;
        state_nxt    = SEND;
      end
      SEND: if (xfer) begin
        tx_valid_nxt = 1'b0;
        idx_nxt      = idx + 9'd1;
        state_nxt    = (idx == IDX_LAST) ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fb_frame_streamer.sv
// Bench for fb_frame_streamer: two instances (400- and 100-clock frames) against a
// byte-stream reference built from a framebuffer model holding mem[i]=i.
module tb_fb_frame_streamer;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         NB   = 257;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, cpu_rd_req = 1'b0, tx_ready = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] fb_addr_a, fb_rdata_a, tx_data_a, drop_cnt_a;
  logic       fb_rd_en_a, tx_valid_a, frame_tick_a, busy_a;
  logic [7:0] fb_addr_b, fb_rdata_b, tx_data_b, drop_cnt_b;
  logic       fb_rd_en_b, tx_valid_b, frame_tick_b, busy_b;

  logic [7:0] mem [256];
  logic [7:0] got_a[$], got_b[$];
  int         vec = 0, miss = 0, stab_err = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always #5 clk = ~clk;

  fb_frame_streamer #(.CLKS_PER_FRAME(400), .FB_BYTES(256), .SYNC_BYTE(SYNC)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cpu_rd_req(cpu_rd_req), .cpu_addr(cpu_addr),
    .fb_addr(fb_addr_a), .fb_rd_en(fb_rd_en_a), .fb_rdata(fb_rdata_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
    .frame_tick(frame_tick_a), .busy(busy_a), .drop_cnt(drop_cnt_a));

  fb_frame_streamer #(.CLKS_PER_FRAME(100), .FB_BYTES(256), .SYNC_BYTE(SYNC)) u_drop (
    .clk(clk), .rst_n(rst_n), .en(en), .cpu_rd_req(cpu_rd_req), .cpu_addr(cpu_addr),
    .fb_addr(fb_addr_b), .fb_rd_en(fb_rd_en_b), .fb_rdata(fb_rdata_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
    .frame_tick(frame_tick_b), .busy(busy_b), .drop_cnt(drop_cnt_b));

  // Framebuffer model: synchronous read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (fb_rd_en_a) fb_rdata_a <= mem[fb_addr_a];
    if (fb_rd_en_b) fb_rdata_b <= mem[fb_addr_b];
  end

  // Transfer log plus hold-stability watch on the 400-clock instance.
  always @(negedge clk) begin
    if (!rst_n) hold = 1'b0;
    else begin
      if (hold && (!tx_valid_a || tx_data_a !== hold_data)) stab_err++;
      hold      = tx_valid_a && !tx_ready;
      hold_data = tx_data_a;
      if (tx_valid_a && tx_ready) got_a.push_back(tx_data_a);
      if (tx_valid_b && tx_ready) got_b.push_back(tx_data_b);
    end
  end

  // Expected stream: one sync byte, then the framebuffer in ascending address order.
  function automatic logic [7:0] exp_byte(input int k);
    return (k == 0) ? SYNC : mem[k-1];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic en_v);
    rst_n = 1'b0; en = 1'b0; tx_ready = 1'b0; cpu_rd_req = 1'b0; cpu_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1; got_a.delete(); got_b.delete(); rst_n = 1'b1; en = en_v;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; en = 1'b1; tx_ready = 1'b1;
    #3;
    vec++; if (tx_valid_a !== 1'b0) begin miss++; $display("FAIL rst tx_valid: got %b want 0", tx_valid_a); end
    vec++; if (tx_data_a !== 8'h00) begin miss++; $display("FAIL rst tx_data: got %h want 00", tx_data_a); end
    vec++; if (frame_tick_a !== 1'b0) begin miss++; $display("FAIL rst frame_tick: got %b want 0", frame_tick_a); end
    vec++; if (busy_a !== 1'b0) begin miss++; $display("FAIL rst busy: got %b want 0", busy_a); end
    vec++; if (drop_cnt_a !== 8'h00) begin miss++; $display("FAIL rst drop_cnt: got %h want 00", drop_cnt_a); end
    vec++; if (fb_rd_en_a !== 1'b0 || fb_addr_a !== 8'h00) begin miss++; $display("FAIL rst fb port: got en=%b addr=%h want 0/00", fb_rd_en_a, fb_addr_a); end
    vec++; if (tx_valid_b !== 1'b0 || drop_cnt_b !== 8'h00) begin miss++; $display("FAIL rst dut_b: got v=%b d=%h want 0/00", tx_valid_b, drop_cnt_b); end
    do_reset(1'b0);
    bad = 0;
    for (int c = 0; c < 450; c++) begin
      @(negedge clk);
      if (frame_tick_a || busy_a) bad++;
      step();
    end
    vec++; if (bad != 0) begin miss++; $display("FAIL en_low_idle: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_stream();
    int t_tick, t_vld, t_last;
    t_tick = -1; t_vld = -1; t_last = -1;
    do_reset(1'b1); tx_ready = 1'b1;
    for (int c = 0; c <= 1170; c++) begin
      @(negedge clk);
      if (frame_tick_a && t_tick < 0) t_tick = c;
      if (tx_valid_a && t_vld < 0) t_vld = c;
      if (tx_valid_a && tx_ready) t_last = c;
      if (c == 401) begin
        vec++; if (fb_rd_en_a !== 1'b1 || fb_addr_a !== 8'h00) begin miss++; $display("FAIL first_read: got en=%b addr=%h want 1/00", fb_rd_en_a, fb_addr_a); end
      end
      if (c == 1170) begin
        vec++; if (busy_a !== 1'b0) begin miss++; $display("FAIL busy_after: got %b want 0", busy_a); end
        // 770-cycle frame from cycle 400: the tick at 799 lands mid-frame, 1199 does not.
        vec++; if (drop_cnt_a !== 8'd1) begin miss++; $display("FAIL drop_stream: got %0d want 1", drop_cnt_a); end
      end
      step();
    end
    vec++; if (t_tick != 399) begin miss++; $display("FAIL tick_cycle: got %0d want 399", t_tick); end
    vec++; if (t_vld != 400) begin miss++; $display("FAIL hdr_cycle: got %0d want 400", t_vld); end
    vec++; if (t_last != 1168) begin miss++; $display("FAIL last_accept: got %0d want 1168", t_last); end
    for (int k = 0; k < NB; k++) begin
      vec++;
      if (k >= got_a.size() || got_a[k] !== exp_byte(k)) begin
        miss++; $display("FAIL stream[%0d]: got %h want %h", k, (k < got_a.size()) ? got_a[k] : 8'hxx, exp_byte(k));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_ready_random();
    int s0;
    s0 = stab_err;
    do_reset(1'b1);
    for (int c = 0; c < 6000 && got_a.size() < NB; c++) begin
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      step();
    end
    for (int k = 0; k < NB; k++) begin
      vec++;
      if (k >= got_a.size() || got_a[k] !== exp_byte(k)) begin
        miss++; $display("FAIL rnd_stream[%0d]: got %h want %h", k, (k < got_a.size()) ? got_a[k] : 8'hxx, exp_byte(k));
      end
    end
    vec++; if (stab_err != s0) begin miss++; $display("FAIL hold_stable: got %0d violations want 0", stab_err - s0); end
    en = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic test_cpu_contention();
    logic       found;
    logic [7:0] prev;
    found = 1'b0; prev = 8'h00;
    do_reset(1'b1); tx_ready = 1'b1;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (tx_valid_a && tx_data_a == 8'h09) found = 1'b1;
      step();
    end
    vec++; if (!found) begin miss++; $display("FAIL cpu_sync: got no byte 09 want one within 1000 cycles"); end
    // The streamer sits in REQ for index 10 from here.
    cpu_rd_req = 1'b1; cpu_addr = 8'($urandom);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vec++;
      if (fb_addr_a !== cpu_addr || fb_rd_en_a !== 1'b1 || tx_valid_a !== 1'b0) begin
        miss++; $display("FAIL cpu_own[%0d]: got addr=%h en=%b v=%b want %h/1/0", i, fb_addr_a, fb_rd_en_a, tx_valid_a, cpu_addr);
      end
      if (i > 0) begin
        vec++; if (fb_rdata_a !== mem[prev]) begin miss++; $display("FAIL cpu_data[%0d]: got %h want %h", i, fb_rdata_a, mem[prev]); end
      end
      prev = cpu_addr;
      step();
      if (i == 49) cpu_rd_req = 1'b0; else cpu_addr = 8'($urandom);
    end
    @(negedge clk);
    vec++; if (fb_rd_en_a !== 1'b1 || fb_addr_a !== 8'd10) begin miss++; $display("FAIL resume_read: got en=%b addr=%h want 1/0a", fb_rd_en_a, fb_addr_a); end
    step();
    for (int c = 0; c < 2000 && got_a.size() < NB; c++) begin @(negedge clk); step(); end
    for (int k = 0; k < NB; k++) begin
      vec++;
      if (k >= got_a.size() || got_a[k] !== exp_byte(k)) begin
        miss++; $display("FAIL cpu_stream[%0d]: got %h want %h", k, (k < got_a.size()) ? got_a[k] : 8'hxx, exp_byte(k));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    int ticks, busies;
    ticks = 0; busies = 0;
    do_reset(1'b1); tx_ready = 1'b1;
    for (int c = 0; c < 2000 && got_a.size() < 6; c++) begin @(negedge clk); step(); end
    en = 1'b0;
    for (int c = 0; c < 2000 && got_a.size() < NB; c++) begin @(negedge clk); step(); end
    for (int k = 0; k < NB; k++) begin
      vec++;
      if (k >= got_a.size() || got_a[k] !== exp_byte(k)) begin
        miss++; $display("FAIL en_stream[%0d]: got %h want %h", k, (k < got_a.size()) ? got_a[k] : 8'hxx, exp_byte(k));
      end
    end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (frame_tick_a) ticks++;
      if (busy_a) busies++;
      step();
    end
    vec++; if (ticks != 0) begin miss++; $display("FAIL en_ticks: got %0d want 0", ticks); end
    vec++; if (busies != 0) begin miss++; $display("FAIL en_busy: got %0d want 0", busies); end
  endtask

  task automatic test_drops();
    int n1, n2;
    n1 = 0; n2 = 0;
    // Ticks fall on cycles 99, 199, ...; the first one starts the frame, the rest are dropped.
    for (int t = 99; t < 1000; t += 100) n1++;
    for (int t = 99; t < 26000; t += 100) n2++;
    n1 = n1 - 1;
    n2 = (n2 - 1 > 255) ? 255 : n2 - 1;
    do_reset(1'b1); tx_ready = 1'b0;
    for (int c = 0; c <= 26000; c++) begin
      @(negedge clk);
      if (c == 1000) begin
        vec++; if (drop_cnt_b !== 8'(n1)) begin miss++; $display("FAIL drop_1000: got %0d want %0d", drop_cnt_b, n1); end
        vec++; if (tx_valid_b !== 1'b1 || tx_data_b !== SYNC) begin miss++; $display("FAIL hdr_hold: got v=%b d=%h want 1/a5", tx_valid_b, tx_data_b); end
      end
      if (c == 26000) begin
        vec++; if (drop_cnt_b !== 8'(n2)) begin miss++; $display("FAIL drop_sat: got %0d want %0d", drop_cnt_b, n2); end
      end
      step();
    end
    tx_ready = 1'b1;
    for (int c = 0; c < 3000 && got_b.size() < NB; c++) begin @(negedge clk); step(); end
    for (int k = 0; k < NB; k++) begin
      vec++;
      if (k >= got_b.size() || got_b[k] !== exp_byte(k)) begin
        miss++; $display("FAIL drop_stream[%0d]: got %h want %h", k, (k < got_b.size()) ? got_b[k] : 8'hxx, exp_byte(k));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1); tx_ready = 1'b1;
    for (int c = 0; c < 2000 && got_a.size() < 20; c++) begin @(negedge clk); step(); end
    tx_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 10 && !tx_valid_a; c++) @(negedge clk);
    vec++; if (tx_valid_a !== 1'b1) begin miss++; $display("FAIL mid_pre: got tx_valid=%b want 1", tx_valid_a); end
    rst_n = 1'b0;
    #1;
    vec++; if (tx_valid_a !== 1'b0 || tx_data_a !== 8'h00) begin miss++; $display("FAIL mid_tx: got v=%b d=%h want 0/00", tx_valid_a, tx_data_a); end
    vec++; if (busy_a !== 1'b0 || frame_tick_a !== 1'b0 || drop_cnt_a !== 8'h00) begin miss++; $display("FAIL mid_state: got busy=%b tick=%b drop=%h want 0/0/00", busy_a, frame_tick_a, drop_cnt_a); end
    vec++; if (fb_rd_en_a !== 1'b0) begin miss++; $display("FAIL mid_rd: got %b want 0", fb_rd_en_a); end
    repeat (2) @(posedge clk);
    #1; got_a.delete(); rst_n = 1'b1; tx_ready = 1'b1;
    for (int c = 0; c < 1000 && got_a.size() < 2; c++) begin @(negedge clk); step(); end
    for (int k = 0; k < 2; k++) begin
      vec++;
      if (k >= got_a.size() || got_a[k] !== exp_byte(k)) begin
        miss++; $display("FAIL restart[%0d]: got %h want %h", k, (k < got_a.size()) ? got_a[k] : 8'hxx, exp_byte(k));
      end
    end
    en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    test_reset();
    test_stream();
    test_ready_random();
    test_cpu_contention();
    test_en_drop();
    test_drops();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
